// File: rtl/baud_acq_gen.sv
// Acquisition (AcqSig) and bit (BaudSig) strobe generator; define BAUD_ACQ_FRAC_EN for the fractional period accumulator.
// Latency: strobes are registered, one clock after the divider wraps.
// Backpressure: none; config is shadowed at bit boundaries, on resync and while disabled.
module baud_acq_gen #(
    parameter int DIV_WIDTH  = 16,
    parameter int FRAC_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  p_Enable_i,
    input  logic [DIV_WIDTH-1:0]  BaudDiv_i,
    input  logic [FRAC_WIDTH-1:0] BaudFrac_i,
    input  logic [3:0]            AcqNumPerBit_i,
    input  logic                  p_Resync_i,
    output logic                  AcqSig_o,
    output logic                  BaudSig_o,
    output logic [3:0]            AcqCnt_o,
    output logic                  p_CfgErr_o
);

    logic [DIV_WIDTH-1:0] sh_div_q, sh_div_d;
    logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
    logic [3:0]           sh_num_q, sh_num_d;
    logic [3:0]           acq_cnt_q, acq_cnt_d;
    logic                 acq_q, acq_d;
    logic                 baud_q, baud_d;
    logic                 err_q, err_d;
    logic                 load_sh;
    logic                 tick;
    logic                 last_acq;
    logic                 carry;
    logic [DIV_WIDTH:0]   period_m1;

`ifdef BAUD_ACQ_FRAC_EN
    logic [FRAC_WIDTH-1:0] sh_frac_q, sh_frac_d;
    logic [FRAC_WIDTH-1:0] frac_acc_q, frac_acc_d;
    logic                  carry_q, carry_d;
    logic [FRAC_WIDTH:0]   frac_sum;

    assign carry    = carry_q;
    assign frac_sum = {1'b0, frac_acc_q} + {1'b0, sh_frac_q};
`else
    logic unused_frac;

    assign carry       = 1'b0;
    assign unused_frac = ^BaudFrac_i;
`endif

    // One extra bit so ShDiv + Carry - 1 cannot overflow at the maximum divisor.
    assign period_m1 = {1'b0, sh_div_q} + {{DIV_WIDTH{1'b0}}, carry} - {{DIV_WIDTH{1'b0}}, 1'b1};
    assign tick      = ({1'b0, div_cnt_q} == period_m1);
    assign last_acq  = (acq_cnt_q == (sh_num_q - 4'd1));

    always_comb begin
        sh_div_d   = sh_div_q;
        sh_num_d   = sh_num_q;
        div_cnt_d  = div_cnt_q;
        acq_cnt_d  = acq_cnt_q;
        acq_d      = 1'b0;
        baud_d     = 1'b0;
        load_sh    = 1'b0;
`ifdef BAUD_ACQ_FRAC_EN
        sh_frac_d  = sh_frac_q;
        frac_acc_d = frac_acc_q;
        carry_d    = carry_q;
`endif
        // Disable and resync both restart the phase; a tick due this cycle is dropped.
        if (!p_Enable_i || p_Resync_i) begin
            load_sh    = 1'b1;
            div_cnt_d  = '0;
            acq_cnt_d  = '0;
`ifdef BAUD_ACQ_FRAC_EN
            frac_acc_d = '0;
            carry_d    = 1'b0;
`endif
        end else if (err_q) begin
            div_cnt_d  = '0;
            acq_cnt_d  = '0;
`ifdef BAUD_ACQ_FRAC_EN
            frac_acc_d = '0;
            carry_d    = 1'b0;
`endif
        end else if (tick) begin
            div_cnt_d  = '0;
            acq_d      = 1'b1;
`ifdef BAUD_ACQ_FRAC_EN
            frac_acc_d = frac_sum[FRAC_WIDTH-1:0];
            carry_d    = frac_sum[FRAC_WIDTH];
`endif
            if (last_acq) begin
                acq_cnt_d = '0;
                baud_d    = 1'b1;
                load_sh   = 1'b1;
            end else begin
                acq_cnt_d = acq_cnt_q + 4'd1;
            end
        end else begin
            div_cnt_d = div_cnt_q + DIV_WIDTH'(1);
        end

        if (load_sh) begin
            sh_div_d  = BaudDiv_i;
            sh_num_d  = AcqNumPerBit_i;
`ifdef BAUD_ACQ_FRAC_EN
            sh_frac_d = BaudFrac_i;
`endif
        end

        // Judged on the next shadow so the flag always matches the config in force.
        err_d = (sh_div_d < DIV_WIDTH'(2)) || (sh_num_d < 4'd2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_div_q  <= '0;
            sh_num_q  <= '0;
            div_cnt_q <= '0;
            acq_cnt_q <= '0;
            acq_q     <= 1'b0;
            baud_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            sh_div_q  <= sh_div_d;
            sh_num_q  <= sh_num_d;
            div_cnt_q <= div_cnt_d;
            acq_cnt_q <= acq_cnt_d;
            acq_q     <= acq_d;
            baud_q    <= baud_d;
            err_q     <= err_d;
        end
    end

`ifdef BAUD_ACQ_FRAC_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_frac_q  <= '0;
            frac_acc_q <= '0;
            carry_q    <= 1'b0;
        end else begin
            sh_frac_q  <= sh_frac_d;
            frac_acc_q <= frac_acc_d;
            carry_q    <= carry_d;
        end
    end
`endif

    assign AcqSig_o   = acq_q;
    assign BaudSig_o  = baud_q;
    assign AcqCnt_o   = acq_cnt_q;
    assign p_CfgErr_o = err_q;

endmodule

// File: tb/tb_baud_acq_gen.sv
// Directed bench for baud_acq_gen: a per-cycle vector table plus multi-cycle pulse-timing sequences.
module tb_baud_acq_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] div;
    logic [3:0]  frac;
    logic [3:0]  num;
    logic        rsy;
    logic        acq;
    logic        baud;
    logic [3:0]  cnt;
    logic        err;

    baud_acq_gen #(.DIV_WIDTH(16), .FRAC_WIDTH(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .p_Enable_i     (en),
        .BaudDiv_i      (div),
        .BaudFrac_i     (frac),
        .AcqNumPerBit_i (num),
        .p_Resync_i     (rsy),
        .AcqSig_o       (acq),
        .BaudSig_o      (baud),
        .AcqCnt_o       (cnt),
        .p_CfgErr_o     (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        en;
        logic [15:0] div;
        logic [3:0]  num;
        logic        rsy;
        logic        acq;
        logic        baud;
        logic [3:0]  cnt;
        logic        err;
    } vec_t;

    vec_t        vt[$];
    int          n_vec = 0;
    int          n_bad = 0;
    int          wide  = 0;
    int          p_idx[$];
    logic        p_baud[$];
    logic [3:0]  p_cnt[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic e, input logic [15:0] d, input logic [3:0] n,
                       input logic s, input logic a, input logic b, input logic [3:0] c,
                       input logic er);
        vec_t v;
        v.rst = r; v.en = e; v.div = d; v.num = n; v.rsy = s;
        v.acq = a; v.baud = b; v.cnt = c; v.err = er;
        vt.push_back(v);
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Runs n sampled cycles, logging every AcqSig pulse; optionally changes BaudDiv_i after sample chg_at.
    task automatic collect(input int n, input int chg_at, input logic [15:0] chg_div);
        logic prev;
        prev = 1'b0;
        p_idx.delete();
        p_baud.delete();
        p_cnt.delete();
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            if (acq) begin
                p_idx.push_back(j);
                p_baud.push_back(baud);
                p_cnt.push_back(cnt);
            end
            if ((acq && prev) || (baud && !acq)) wide++;
            prev = acq;
            if (j == chg_at) div = chg_div;
        end
    endtask

    task automatic chk_pulses(input string tag, input int n_exp, input int ei[8], input logic [7:0] eb);
        chk({tag, "_npulse"}, 32'(p_idx.size()), 32'(n_exp));
        for (int k = 0; k < n_exp; k++) begin
            int   ai;
            logic ab;
            ai = (k < p_idx.size()) ? p_idx[k] : -1;
            ab = (k < p_baud.size()) ? p_baud[k] : 1'bx;
            chk($sformatf("%s_idx%0d", tag, k), 32'(ai), 32'(ei[k]));
            chk($sformatf("%s_baud%0d", tag, k), 32'(ab), 32'(eb[k]));
        end
    endtask

    initial begin
        int cnt_exp[29];
        int ei[8];
        int bad;

        rst = 1'b1; en = 1'b0; div = 16'd4; frac = 4'd0; num = 4'd4; rsy = 1'b0;

        // Reset, shadow load while disabled, then Div=4 Num=4 from enable edge j=0.
        add(1, 0, 4, 4, 0, 0, 0, 0, 0);
        add(0, 0, 4, 4, 0, 0, 0, 0, 0);
        cnt_exp = '{0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0,0,0,0,1,1,1,1,0,0,0,0,1,1};
        for (int j = 0; j < 29; j++) begin
            add(0, 1, 4, 4, (j == 23), (j inside {3, 7, 11, 15, 19, 27}), (j == 15),
                4'(cnt_exp[j]), 0);
        end
        // Illegal divisor: latched while disabled, input change ignored, cleared by resync.
        add(0, 0, 1, 4, 0, 0, 0, 0, 1);
        add(0, 1, 1, 4, 0, 0, 0, 0, 1);
        add(0, 1, 4, 4, 0, 0, 0, 0, 1);
        add(0, 1, 4, 4, 1, 0, 0, 0, 0);
        add(0, 1, 4, 4, 0, 0, 0, 0, 0);
        add(0, 0, 4, 1, 0, 0, 0, 0, 1);

        for (int i = 0; i < vt.size(); i++) begin
            rst = vt[i].rst; en = vt[i].en; div = vt[i].div; num = vt[i].num; rsy = vt[i].rsy;
            cyc();
            chk($sformatf("vec%0d", i), 32'({acq, baud, cnt, err}),
                32'({vt[i].acq, vt[i].baud, vt[i].cnt, vt[i].err}));
        end
        rsy = 1'b0;

        // Num=1 held for 100 enabled cycles: no strobes, error stays up.
        en = 1'b1;
        bad = 0;
        for (int j = 0; j < 100; j++) begin
            cyc();
            if (acq || baud || !err) bad++;
        end
        chk("cfgerr_quiet", 32'(bad), 32'd0);

        // Restore legal config through a disabled cycle.
        en = 1'b0; div = 16'd4; num = 4'd4;
        cyc();
        chk("cfgerr_clear", 32'(err), 32'd0);
        en = 1'b1;
        collect(8, -1, 16'd0);
        ei = '{3, 7, 0, 0, 0, 0, 0, 0};
        chk_pulses("restore", 2, ei, 8'b0000_0000);
        chk("restore_cnt0", 32'(p_cnt.size() > 0 ? p_cnt[0] : 4'hf), 32'd1);

        // Div=10 Frac=8 Num=2.
        en = 1'b0; div = 16'd10; frac = 4'd8; num = 4'd2;
        cyc(); cyc();
        en = 1'b1;
        collect(55, -1, 16'd0);
`ifdef BAUD_ACQ_FRAC_EN
        ei = '{9, 19, 30, 40, 51, 0, 0, 0};
`else
        ei = '{9, 19, 29, 39, 49, 0, 0, 0};
`endif
        chk_pulses("frac", 5, ei, 8'b0000_1010);

        // BaudDiv_i 4 -> 8 mid-bit; new spacing only after the BaudSig tick.
        en = 1'b0; div = 16'd4; frac = 4'd0; num = 4'd4;
        cyc(); cyc();
        en = 1'b1;
        collect(48, 3, 16'd8);
        ei = '{3, 7, 11, 15, 23, 31, 39, 47};
        chk_pulses("divchg", 8, ei, 8'b1000_1000);

        // Disable mid-bit.
        en = 1'b0; div = 16'd4;
        cyc(); cyc();
        en = 1'b1;
        for (int j = 0; j < 6; j++) cyc();
        chk("midbit_cnt", 32'(cnt), 32'd1);
        en = 1'b0;
        cyc();
        chk("disable_out", 32'({acq, baud, cnt}), 32'd0);
        en = 1'b1;
        collect(8, -1, 16'd0);
        ei = '{3, 7, 0, 0, 0, 0, 0, 0};
        chk_pulses("reen", 2, ei, 8'b0000_0000);
        chk("reen_cnt0", 32'(p_cnt.size() > 0 ? p_cnt[0] : 4'hf), 32'd1);

        // Reset mid-bit with enable still high.
        for (int j = 0; j < 5; j++) cyc();
        rst = 1'b1;
        cyc();
        chk("rst_out", 32'({acq, baud, cnt, err}), 32'd0);
        rst = 1'b0; en = 1'b0;
        cyc();
        en = 1'b1;
        collect(5, -1, 16'd0);
        ei = '{3, 0, 0, 0, 0, 0, 0, 0};
        chk_pulses("postrst", 1, ei, 8'b0000_0000);

        chk("single_clk_strobes", 32'(wide), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
